// File: rtl/fp_cmd_dispatcher.sv
// fp_cmd_dispatcher: queues {op,A,B} commands, computes add/sub/mul, ships {HDR,op,A,B,result} frames to a link master; optional WAIT timeout under DISPATCH_TIMEOUT_EN
module fp_cmd_dispatcher #(
  parameter int DATA_W = 32,
  parameter int OP_W = 2,
  parameter int DEPTH = 4,
  parameter logic [5:0] HDR = 6'b111111,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic [OP_W+2*DATA_W-1:0] cmd_data,
  output logic tx_valid,
  input  logic tx_ready,
  output logic [6+OP_W+3*DATA_W-1:0] tx_frame,
  input  logic tx_done,
  input  logic clr_err,
  output logic done,
  output logic busy,
  output logic err_op,
  output logic err_to,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [2:0] st
);
  localparam int CMD_W = OP_W + 2 * DATA_W;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] EXEC = 3'd2;
  localparam logic [2:0] SEND = 3'd3;
  localparam logic [2:0] WAIT = 3'd4;
  localparam logic [2:0] DONE = 3'd5;
  logic [2:0] state, nxt;
  logic [CMD_W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [OP_W-1:0] op;
  logic [DATA_W-1:0] a, b, res, alu;
  logic push, pop, bad_op, to_hit;
  assign cmd_ready = reset_n && (level != LW'(DEPTH));
  assign push = cmd_valid && cmd_ready;
  assign pop = state == FETCH;
  assign bad_op = op > OP_W'(2);
  assign tx_valid = state == SEND;
  assign tx_frame = {HDR, op, a, b, res};
  assign done = state == DONE;
  assign busy = state != IDLE;
  assign st = state;
  always_comb begin
    alu = op == OP_W'(0) ? a + b : op == OP_W'(1) ? a - b : a * b;
  end
  always_comb begin
    nxt = state == IDLE  ? (level != '0 ? FETCH : IDLE) :
          state == FETCH ? EXEC :
          state == EXEC  ? (bad_op ? DONE : SEND) :
          state == SEND  ? (tx_ready ? WAIT : SEND) :
          state == WAIT  ? ((tx_done || to_hit) ? DONE : WAIT) :
          IDLE;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= cmd_data;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      level <= '0;
      op <= '0;
      a <= '0;
      b <= '0;
      res <= '0;
      err_op <= 1'b0;
    end else begin
      state <= nxt;
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      level <= level + LW'(push) - LW'(pop);
      if (pop) {op, a, b} <= mem[rp];
      if (state == EXEC) res <= bad_op ? '0 : alu;
      err_op <= (state == EXEC && bad_op) ? 1'b1 : clr_err ? 1'b0 : err_op;
    end
  end
`ifdef DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] cnt;
  // tx_done on the terminal cycle takes priority over the timeout
  assign to_hit = state == WAIT && !tx_done && cnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      err_to <= 1'b0;
    end else begin
      cnt <= state == WAIT ? cnt + TW'(1) : '0;
      err_to <= to_hit ? 1'b1 : clr_err ? 1'b0 : err_to;
    end
  end
`else
  assign to_hit = 1'b0;
  assign err_to = 1'b0;
`endif
endmodule

// File: tb/tb_fp_cmd_dispatcher.sv
// tb_fp_cmd_dispatcher: scoreboard bench for fp_cmd_dispatcher
module tb_fp_cmd_dispatcher;
  logic clk = 1'b0;
  logic reset_n, cmd_valid, cmd_ready, tx_valid, tx_ready, tx_done, clr_err;
  logic done, busy, err_op, err_to;
  logic [65:0] cmd_data;
  logic [103:0] tx_frame;
  logic [2:0] level, st;
  logic [103:0] q[$];
  logic [103:0] prev_frame;
  logic prev_valid, prev_acc, prev_done, saw_valid, auto_done, force_done;
  int n_tests, n_fail, done_cnt, wait_cyc, exp_done, wcnt;
  always #5 clk = ~clk;
  fp_cmd_dispatcher #(.TIMEOUT_CYC(10)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_frame(tx_frame),
    .tx_done(tx_done), .clr_err(clr_err), .done(done), .busy(busy), .err_op(err_op),
    .err_to(err_to), .level(level), .st(st)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [103:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = op == 2'd0 ? a + b : op == 2'd1 ? a - b : a * b;
    return {6'h3F, op, a, b, r};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic acc;
    acc = 1'b0;
    cmd_data = {op, a, b};
    cmd_valid = 1'b1;
    if (op != 2'd3) q.push_back(model(op, a, b));
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      tick();
    end
    if (!acc) check("push_accept", acc, 1);
    cmd_valid = 1'b0;
  endtask
  task automatic wait_done();
    exp_done++;
    for (int i = 0; i < 200 && done_cnt < exp_done; i++) tick();
    check("done_cnt", done_cnt, exp_done);
  endtask
  task automatic check_reset_vals();
    check("rst_cmd_ready", cmd_ready, reset_n);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_st", st, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_done", done, 0);
    check("rst_err_op", err_op, 0);
    check("rst_err_to", err_to, 0);
  endtask
  always @(negedge clk) begin
    tx_done = force_done;
    if (auto_done && st == 3'd4) begin
      wcnt++;
      if (wcnt == 2) tx_done = 1'b1;
    end else wcnt = 0;
  end
  always @(negedge clk) begin
    if (tx_valid) saw_valid = 1'b1;
    if (tx_valid && prev_valid && !prev_acc) check("frame_stable", tx_frame, prev_frame);
    if (tx_valid && tx_ready) begin
      check("sb_nonempty", q.size() > 0, 1);
      if (q.size() > 0) check("frame", tx_frame, q.pop_front());
    end
    if (done) begin
      check("done_1cyc", prev_done, 0);
      done_cnt++;
    end
    if (st == 3'd4) wait_cyc++;
    prev_valid = tx_valid;
    prev_acc = tx_valid && tx_ready;
    prev_frame = tx_frame;
    prev_done = done;
  end
  initial begin
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_data = '0;
    tx_ready = 1'b0;
    tx_done = 1'b0;
    clr_err = 1'b0;
    auto_done = 1'b1;
    force_done = 1'b0;
    saw_valid = 1'b0;
    prev_valid = 1'b0;
    prev_acc = 1'b0;
    prev_done = 1'b0;
    prev_frame = '0;
    wcnt = 0;
    repeat (3) tick();
    check_reset_vals();
    reset_n = 1'b1;
    tick();
    check("ready_after_rst", cmd_ready, 1);
    tx_ready = 1'b1;
    push(2'd0, 32'd3, 32'd4);
    tick();
    check("lat_e1", tx_valid, 0);
    tick();
    check("lat_e2", tx_valid, 0);
    tick();
    check("lat_e3", tx_valid, 1);
    check("frame_add", tx_frame, {6'h3F, 2'd0, 32'd3, 32'd4, 32'd7});
    wait_done();
    check("idle_after_done", busy, 0);
    check("err_to_clear", err_to, 0);
    push(2'd1, 32'd0, 32'd1);
    push(2'd2, 32'h10000, 32'h10000);
    wait_done();
    wait_done();
    saw_valid = 1'b0;
    push(2'd3, 32'd5, 32'd5);
    wait_done();
    check("err_no_frame", saw_valid, 0);
    check("err_op_set", err_op, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("err_op_clr", err_op, 0);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(2'(i % 3), $urandom, $urandom);
    repeat (3) tick();
    check("full_level", level, 4);
    check("full_ready", cmd_ready, 0);
    check("stall_send", st, 3);
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    tick();
    check("tx_done_ignored", st, 3);
    tx_ready = 1'b1;
    repeat (5) wait_done();
    check("drained_level", level, 0);
    check("sb_drained", q.size(), 0);
`ifdef DISPATCH_TIMEOUT_EN
    auto_done = 1'b0;
    wait_cyc = 0;
    push(2'd0, 32'd1, 32'd2);
    wait_done();
    check("to_err", err_to, 1);
    check("to_wait_cycles", wait_cyc, 10);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("to_clr", err_to, 0);
    auto_done = 1'b1;
    push(2'd1, 32'd9, 32'd4);
    wait_done();
    check("to_next_ok", err_to, 0);
`endif
    auto_done = 1'b0;
    push(2'd0, 32'd10, 32'd20);
    push(2'd1, 32'd7, 32'd2);
    push(2'd2, 32'd6, 32'd7);
    for (int i = 0; i < 20 && st != 3'd4; i++) tick();
    check("pre_rst_wait", st, 4);
    check("pre_rst_level", level, 2);
    reset_n = 1'b0;
    #2;
    q.delete();
    check_reset_vals();
    @(negedge clk);
    reset_n = 1'b1;
    saw_valid = 1'b0;
    repeat (5) tick();
    check("post_rst_idle", busy, 0);
    check("post_rst_level", level, 0);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_no_tx", saw_valid, 0);
    auto_done = 1'b1;
    push(2'd0, 32'hFFFFFFFF, 32'd2);
    wait_done();
    check("final_sb", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
